// File: rtl/dlx_pkg.sv
// -----------------------------------------------------------------------------
// dlx_pkg
// Shared definitions for the DLX pipeline: default datapath widths, reset PC,
// sequential PC step, the fetch-queue state encoding and the queue entry
// layout delivered to instruction decode.
// -----------------------------------------------------------------------------
package dlx_pkg;

    localparam int DLX_PC_WIDTH          = 20;
    localparam int DLX_INSTRUCTION_WIDTH = 32;
    localparam int DLX_REG_ADDR_WIDTH    = 5;
    localparam int DLX_OPCODE_WIDTH      = 6;

    localparam logic [DLX_PC_WIDTH-1:0] DLX_PC_INITIAL_ADDRESS = 20'h40000;
    localparam int                      DLX_PC_INCREMENT       = 4;
    localparam int                      DLX_QUEUE_DEPTH        = 4;

    // RUN: every response is kept. DRAIN: responses issued before the last
    // redirect are still in flight and get thrown away as they return.
    typedef enum logic {
        FQ_RUN   = 1'b0,
        FQ_DRAIN = 1'b1
    } fq_state_t;

    // One decoded-side queue entry at the default widths.
    typedef struct packed {
        logic [DLX_INSTRUCTION_WIDTH-1:0] instruction;
        logic [DLX_PC_WIDTH-1:0]          new_pc;
    } fq_entry_t;

endpackage

// File: rtl/dlx_sync_fifo.sv
// -----------------------------------------------------------------------------
// dlx_sync_fifo
// Single-clock FIFO with first-word fall-through read port. The head word is
// read straight out of the storage registers, so a word pushed into an empty
// FIFO shows up on pop_data one cycle after the push.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   push        write push_data (ignored when full)
//   push_data   WIDTH-bit write data
//   pop         advance past the head word (ignored when empty)
//   clear       synchronous flush; wins over push and pop
//   pop_data    head word (meaningful only when !empty)
//   full/empty  status flags
//   count       number of stored words, 0..DEPTH
// -----------------------------------------------------------------------------
module dlx_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  logic [WIDTH-1:0]               push_data,
    input  logic                           pop,
    input  logic                           clear,
    output logic [WIDTH-1:0]               pop_data,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            // NOTE: the storage is a handful of flops feeding an output port
            // directly, so it is reset to keep the head word at zero out of reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/dlx_fetch_queue.sv
// -----------------------------------------------------------------------------
// dlx_fetch_queue
// Decoupled instruction prefetch unit. Issues pipelined reads to instruction
// memory, collects in-order responses into a QUEUE_DEPTH-entry queue and hands
// {instruction, address + PC_INCREMENT} to decode over valid/ready. A redirect
// from execute flushes the queue and marks every read still in flight as
// stale; stale responses are dropped as they come back.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   instr_rd_en        read request (issue = instr_rd_en & instr_gnt)
//   instr_addr         request address (current fetch PC)
//   instr_gnt          memory accepts the request this cycle
//   instr_rvalid       response valid, responses return in issue order
//   instruction        response data
//   select_new_pc_in   redirect strobe
//   new_pc_in          redirect target
//   halt_in            stop issuing; in-flight reads still complete
//   if_valid_out       queue head valid
//   id_ready_in        decode takes the head (pop = if_valid_out & id_ready_in)
//   instruction_out    head instruction
//   new_pc_out         head instruction address + PC_INCREMENT
//   flush_busy_out     stale responses still pending discard
// -----------------------------------------------------------------------------
module dlx_fetch_queue
    import dlx_pkg::*;
#(
    parameter int                    PC_WIDTH           = DLX_PC_WIDTH,
    parameter int                    INSTRUCTION_WIDTH  = DLX_INSTRUCTION_WIDTH,
    parameter int                    QUEUE_DEPTH        = DLX_QUEUE_DEPTH,
    parameter logic [PC_WIDTH-1:0]   PC_INITIAL_ADDRESS = PC_WIDTH'(DLX_PC_INITIAL_ADDRESS),
    parameter int                    PC_INCREMENT       = DLX_PC_INCREMENT
) (
    input  logic                         clk,
    input  logic                         rst_n,
    output logic                         instr_rd_en,
    output logic [PC_WIDTH-1:0]          instr_addr,
    input  logic                         instr_gnt,
    input  logic                         instr_rvalid,
    input  logic [INSTRUCTION_WIDTH-1:0] instruction,
    input  logic                         select_new_pc_in,
    input  logic [PC_WIDTH-1:0]          new_pc_in,
    input  logic                         halt_in,
    output logic                         if_valid_out,
    input  logic                         id_ready_in,
    output logic [INSTRUCTION_WIDTH-1:0] instruction_out,
    output logic [PC_WIDTH-1:0]          new_pc_out,
    output logic                         flush_busy_out
);

    localparam int CW = $clog2(QUEUE_DEPTH + 1);

    typedef struct packed {
        logic [INSTRUCTION_WIDTH-1:0] instruction;
        logic [PC_WIDTH-1:0]          new_pc;
    } entry_t;

    localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(PC_INCREMENT);

    fq_state_t           state;
    logic [PC_WIDTH-1:0] fetch_pc;
    logic [CW-1:0]       outstanding;
    logic [CW-1:0]       discard_cnt;
    logic [CW-1:0]       residual;
    logic [CW:0]         in_use;

    logic                redirect;
    logic                issue;
    logic                keep_resp;
    logic                drop_resp;
    logic                pop;

    entry_t              push_entry;
    entry_t              head_entry;
    logic                q_full;
    logic                q_empty;
    logic [CW-1:0]       occupancy;

    logic [PC_WIDTH-1:0] resp_addr;
    logic                a_full;
    logic                a_empty;
    logic [CW-1:0]       a_count;

    // ---------------------------------------------------------------- control
    assign redirect = select_new_pc_in;

    // Credit check: queue slots already used plus reads that will land in the
    // queue must leave room, so a response can never find the queue full.
    assign in_use      = {1'b0, occupancy} + {1'b0, outstanding};
    assign instr_rd_en = ~redirect & ~halt_in & (in_use < (CW+1)'(QUEUE_DEPTH));
    assign instr_addr  = fetch_pc;
    assign issue       = instr_rd_en & instr_gnt;

    // A response arriving on the redirect cycle is already stale.
    assign keep_resp = instr_rvalid & ~redirect & (discard_cnt == '0);
    assign drop_resp = instr_rvalid & ~redirect & (discard_cnt != '0);
    assign residual  = outstanding - CW'(instr_rvalid);

    assign pop = if_valid_out & id_ready_in & ~redirect;

    // ------------------------------------------------------------- datapaths
    assign push_entry.instruction = instruction;
    assign push_entry.new_pc      = resp_addr + PC_STEP;

    // Addresses of non-stale in-flight reads, oldest first.
    dlx_sync_fifo #(
        .WIDTH (PC_WIDTH),
        .DEPTH (QUEUE_DEPTH)
    ) u_addr_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (issue),
        .push_data (fetch_pc),
        .pop       (keep_resp),
        .clear     (redirect),
        .pop_data  (resp_addr),
        .full      (a_full),
        .empty     (a_empty),
        .count     (a_count)
    );

    dlx_sync_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (QUEUE_DEPTH)
    ) u_entry_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (keep_resp),
        .push_data (push_entry),
        .pop       (pop),
        .clear     (redirect),
        .pop_data  (head_entry),
        .full      (q_full),
        .empty     (q_empty),
        .count     (occupancy)
    );

    assign if_valid_out    = ~q_empty;
    assign instruction_out = head_entry.instruction;
    assign new_pc_out      = head_entry.new_pc;

    // ------------------------------------------------ fetch PC, counters, FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc       <= PC_INITIAL_ADDRESS;
            outstanding    <= '0;
            discard_cnt    <= '0;
            state          <= FQ_RUN;
            flush_busy_out <= 1'b0;
        end else begin
            // NOTE: every register here uses <= so all of them update from the
            // same pre-edge values regardless of statement order.
            outstanding <= outstanding + CW'(issue) - CW'(instr_rvalid);

            if (redirect) begin
                // Everything still in flight after this cycle is stale.
                fetch_pc       <= new_pc_in;
                discard_cnt    <= residual;
                state          <= (residual != '0) ? FQ_DRAIN : FQ_RUN;
                flush_busy_out <= (residual != '0);
            end else begin
                if (issue) begin
                    fetch_pc <= fetch_pc + PC_STEP;
                end
                case (state)
                    FQ_RUN: begin
                        flush_busy_out <= 1'b0;
                    end
                    FQ_DRAIN: begin
                        if (drop_resp) begin
                            discard_cnt <= discard_cnt - 1'b1;
                            if (discard_cnt == CW'(1)) begin
                                state          <= FQ_RUN;
                                flush_busy_out <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state          <= FQ_RUN;
                        flush_busy_out <= 1'b0;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------ assertions
    a_rvalid_has_req: assert property (@(posedge clk) disable iff (!rst_n)
        instr_rvalid |-> (outstanding != '0))
        else $error("instr_rvalid with no outstanding read");

    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
        keep_resp |-> (~q_full & ~a_empty));

    a_no_issue_full: assert property (@(posedge clk) disable iff (!rst_n)
        issue |-> ~a_full);

    a_addr_tracks: assert property (@(posedge clk) disable iff (!rst_n)
        a_count == CW'(outstanding - discard_cnt));

endmodule
